sram_prefetch_fifo: RTL and testbench

Next-generation SRAM-backed FIFO for the EC accelerator datapath. A simple-dual-port memory array (1 write port, 1 read port, 1-cycle read latency) is fronted by a 2-entry prefetch output stage, so the block sustains one push and one pop per cycle, including simultaneous push and pop. It uses valid/ready handshakes, supports any depth (not only powers of two), and reports level, almost-full and almost-empty status. Stream buffers between encoder stages instantiate it.

---
 rtl/sram_prefetch_fifo.sv | 137 +++++++++++++
 tb/tb_sram_prefetch_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_prefetch_fifo.sv
// SRAM-backed valid/ready FIFO with a 2-entry prefetch head stage. An empty FIFO shows a push 1 cycle later; memory entries take 2 cycles.
// in_ready drops only at level==CAP and is independent of out_ready. A push and a pop can occur in the same cycle.
module sram_prefetch_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 100,
    parameter int AF_THRESH = DEPTH,
    parameter int AE_THRESH = 1,
    parameter int CNT_W     = $clog2(DEPTH + 3)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] level,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty
);

    localparam int CAP   = DEPTH + 2;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] mem_rd_q, mem_rd_d;

    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
    logic [CNT_W-1:0] level_q, level_d;
    logic             rd_inflight_q, rd_inflight_d;
    logic [1:0]       os_cnt_q, os_cnt_d;
    logic [WIDTH-1:0] os_dat_q [2];
    logic [WIDTH-1:0] os_dat_d [2];

    logic       push, pop, bypass, mem_wr, rd_issue;
    logic [2:0] os_proj;
    logic [1:0] os_fill;

    assign full         = (level_q == CNT_W'(CAP));
    assign empty        = (level_q == '0);
    assign in_ready     = ~full;
    assign almost_full  = (int'(level_q) >= AF_THRESH);
    assign almost_empty = (int'(level_q) <= AE_THRESH);
    assign level        = level_q;
    assign out_valid    = (os_cnt_q != 2'd0);
    assign out_data     = os_dat_q[0];

    always_comb begin
        push     = in_valid & in_ready & ~flush;
        pop      = out_valid & out_ready & ~flush;
        // Bypass only while nothing older sits in memory or in the read pipe.
        bypass   = push & (mem_cnt_q == '0) & ~rd_inflight_q & (os_cnt_q != 2'd2);
        mem_wr   = push & ~bypass;
        os_proj  = 3'(os_cnt_q) + 3'(rd_inflight_q) - 3'(pop);
        rd_issue = ~flush & (mem_cnt_q != '0) & (os_proj < 3'd2);
        mem_rd_d = mem[rptr_q];

        wptr_d = wptr_q;
        if (mem_wr) begin
            wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
        end
        rptr_d = rptr_q;
        if (rd_issue) begin
            rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
        end

        mem_cnt_d     = mem_cnt_q + CNT_W'(mem_wr) - CNT_W'(rd_issue);
        level_d       = level_q + CNT_W'(push) - CNT_W'(pop);
        rd_inflight_d = rd_issue;

        // Shift on pop, then append the returning read, then the bypassed push.
        os_dat_d = os_dat_q;
        os_fill  = os_cnt_q;
        if (pop) begin
            os_dat_d[0] = os_dat_q[1];
            os_fill     = os_cnt_q - 2'd1;
        end
        if (rd_inflight_q) begin
            os_dat_d[os_fill[0]] = mem_rd_q;
            os_fill              = os_fill + 2'd1;
        end
        if (bypass) begin
            os_dat_d[os_fill[0]] = in_data;
            os_fill              = os_fill + 2'd1;
        end
        os_cnt_d = os_fill;

        if (flush) begin
            wptr_d        = '0;
            rptr_d        = '0;
            mem_cnt_d     = '0;
            level_d       = '0;
            rd_inflight_d = 1'b0;
            os_cnt_d      = 2'd0;
            os_dat_d[0]   = '0;
            os_dat_d[1]   = '0;
        end
    end

    // Storage array and its read register carry no reset; validity lives in the counters.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wptr_q] <= in_data;
        end
        if (rd_issue) begin
            mem_rd_q <= mem_rd_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            mem_cnt_q     <= '0;
            level_q       <= '0;
            rd_inflight_q <= 1'b0;
            os_cnt_q      <= 2'd0;
            os_dat_q[0]   <= '0;
            os_dat_q[1]   <= '0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            mem_cnt_q     <= mem_cnt_d;
            level_q       <= level_d;
            rd_inflight_q <= rd_inflight_d;
            os_cnt_q      <= os_cnt_d;
            os_dat_q[0]   <= os_dat_d[0];
            os_dat_q[1]   <= os_dat_d[1];
        end
    end

endmodule

// File: tb/tb_sram_prefetch_fifo.sv
// Bench for sram_prefetch_fifo at DEPTH=5 (CAP=7): queue-based reference model plus directed literal checks.
module tb_sram_prefetch_fifo;

    localparam int W   = 32;
    localparam int D   = 5;
    localparam int CAP = D + 2;
    localparam int AFT = 5;
    localparam int AET = 2;
    localparam int CW  = $clog2(D + 3);

    logic          clk = 1'b0;
    logic          rstn;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] level;
    logic          full, empty, almost_full, almost_empty;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sram_prefetch_fifo #(
        .WIDTH(W), .DEPTH(D), .AF_THRESH(AFT), .AE_THRESH(AET)
    ) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference model: contents as a plain queue; head visibility bounded by latency rules.
    logic [W-1:0] mq[$];
    int bubble_run = 0;
    bit exp_valid  = 1'b0;
    bit was_flush  = 1'b0;

    always @(negedge clk) begin
        int  n;
        bit  m_pop, m_push;
        if (!rstn) begin
            mq.delete();
            bubble_run = 0;
            exp_valid  = 1'b0;
            was_flush  = 1'b0;
            check("rst_out_valid", 32'(out_valid), 32'(0));
            check("rst_out_data", out_data, 32'(0));
            check("rst_level", 32'(level), 32'(0));
            check("rst_empty", 32'(empty), 32'(1));
            check("rst_full", 32'(full), 32'(0));
            check("rst_almost_empty", 32'(almost_empty), 32'(1));
            check("rst_almost_full", 32'(almost_full), 32'(0));
            check("rst_in_ready", 32'(in_ready), 32'(1));
        end else begin
            n = mq.size();
            check("level", 32'(level), 32'(n));
            check("empty", 32'(empty), 32'(n == 0));
            check("full", 32'(full), 32'(n == CAP));
            check("almost_full", 32'(almost_full), 32'(n >= AFT));
            check("almost_empty", 32'(almost_empty), 32'(n <= AET));
            check("in_ready", 32'(in_ready), 32'(n != CAP));
            if (n == 0) check("idle_valid", 32'(out_valid), 32'(0));
            else if (out_valid) check("head_data", out_data, mq[0]);
            if (exp_valid) check("bypass_latency", 32'(out_valid), 32'(1));
            if (was_flush) check("flush_data", out_data, 32'(0));
            if (n > 0 && !out_valid) begin
                bubble_run++;
                check("head_wait", 32'(bubble_run > 2), 32'(0));
            end else begin
                bubble_run = 0;
            end

            was_flush = flush;
            if (flush) begin
                mq.delete();
                exp_valid = 1'b0;
            end else begin
                m_pop     = out_valid && out_ready && (n > 0);
                m_push    = in_valid && (n != CAP);
                exp_valid = m_push && (n == 0);
                if (m_pop) void'(mq.pop_front());
                if (m_push) mq.push_back(in_data);
            end
        end
    end

    task automatic cyc(input bit v, input logic [31:0] d, input bit r, input bit f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int budget = 40;
        while (!empty && budget > 0) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
            budget--;
        end
        check(name, 32'(empty), 32'(1));
    endtask

    initial begin
        int got;
        int budget;
        int pin, pout;
        rstn      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Single push into an empty FIFO.
        cyc(1'b1, 32'hA1, 1'b0, 1'b0);
        check("t1_valid", 32'(out_valid), 32'(1));
        check("t1_data", out_data, 32'hA1);
        check("t1_level", 32'(level), 32'(1));
        check("t1_empty", 32'(empty), 32'(0));
        drain("t1_drain");

        // Fill to capacity and drain, three rounds to wrap the pointers.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < CAP; i++) cyc(1'b1, 32'(r * 16 + i), 1'b0, 1'b0);
            check("fill_level", 32'(level), 32'(CAP));
            check("fill_full", 32'(full), 32'(1));
            check("fill_in_ready", 32'(in_ready), 32'(0));
            check("fill_head", out_data, 32'(r * 16));
            cyc(1'b1, 32'hBEEF, 1'b1, 1'b0);
            check("full_push_pop_level", 32'(level), 32'(CAP - 1));
            got    = 1;
            budget = 40;
            while (got < CAP && budget > 0) begin
                if (out_valid) begin
                    check("drain_data", out_data, 32'(r * 16 + got));
                    got++;
                end
                cyc(1'b0, 32'h0, 1'b1, 1'b0);
                budget--;
            end
            check("drain_count", 32'(got), 32'(CAP));
            check("drain_empty", 32'(empty), 32'(1));
        end

        // Near-full steady push+pop exercising memory reads.
        for (int i = 0; i < CAP - 1; i++) cyc(1'b1, 32'(32'h200 + i), 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 32'(32'h100 + i), 1'b1, 1'b0);
            check("nf_level", 32'(level), 32'(CAP - 1));
            check("nf_valid", 32'(out_valid), 32'(1));
        end
        drain("nf_drain");

        // Continuous streaming from empty: no bubbles.
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 32'(i), 1'b1, 1'b0);
            check("stream_valid", 32'(out_valid), 32'(1));
            check("stream_data", out_data, 32'(i));
            check("stream_level", 32'(level), 32'(1));
        end
        drain("stream_drain");

        // Flush with a read in flight.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'(32'hC0 + i), 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("pre_flush_level", 32'(level), 32'(3));
        cyc(1'b1, 32'hEE, 1'b1, 1'b1);
        check("flush_level", 32'(level), 32'(0));
        check("flush_valid", 32'(out_valid), 32'(0));
        check("flush_out_data", out_data, 32'(0));
        check("flush_in_ready", 32'(in_ready), 32'(1));
        cyc(1'b1, 32'h55, 1'b0, 1'b0);
        check("post_flush_valid", 32'(out_valid), 32'(1));
        check("post_flush_data", out_data, 32'h55);
        check("post_flush_level", 32'(level), 32'(1));
        repeat (3) cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check("no_stale_level", 32'(level), 32'(1));
        check("no_stale_data", out_data, 32'h55);
        drain("flush_drain");

        // Randomized traffic with occasional flush and one mid-cycle async reset.
        for (int seg = 0; seg < 12; seg++) begin
            pin  = $urandom_range(95, 20);
            pout = $urandom_range(95, 20);
            for (int k = 0; k < 250; k++) begin
                if (seg == 5 && k == 100) begin
                    #2 rstn = 1'b0;
                    in_valid  = 1'b0;
                    out_ready = 1'b0;
                    flush     = 1'b0;
                    repeat (2) @(posedge clk);
                    #2 rstn = 1'b1;
                end else begin
                    cyc(32'($urandom_range(99)) < pin, $urandom,
                        32'($urandom_range(99)) < pout, $urandom_range(99) == 0);
                end
            end
        end
        drain("final_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
